prbs_bit_checker: RTL
=====================

# prbs_bit_checker

Serial checker for the 31-bit XNOR-feedback LFSR pseudo-random stream (feedback = NOT(r[3] XOR r[0]), right shift) used for perturbation generation. It consumes one stream bit per valid cycle, self-synchronises to the sequence phase without knowing the seed, then predicts every following bit and flags mismatches. It sits on the receive side of test and loopback paths, for example on a link carrying bit 0 of the generator output, and reports lock status and error statistics to the control logic.

## Interface
- REG_WIDTH, 31, LFSR length; also the number of history bits.
- TAP, 3, second feedback tap index; the other tap is 0.
- CONFIRM, 16, consecutive correct predictions required before lock.
- ERR_THRESH, 8, errors within one window that cause loss of lock.
- WINDOW, 256, window length in checked bits while locked.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- in_valid  in  1  in_bit is sampled on this cycle.
- in_bit  in  1  received stream bit.
- clear  in  1  synchronous clear of err_count and bit_count.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  one-cycle flag: the previous valid bit mismatched while in LOCKED.
- err_count  out  16  errors seen in LOCKED, saturating at 0xFFFF.
- bit_count  out  32  bits checked in LOCKED, saturating at 0xFFFFFFFF.

## Operation
- History register hist[REG_WIDTH-1:0]. On every valid bit: hist <= {in_bit, hist[REG_WIDTH-1:1]}. The received bit is always shifted in, never the predicted bit.
- Prediction: exp = NOT(hist[TAP] XOR hist[0]). It is compared with in_bit on valid cycles in VERIFY and LOCKED.
- States:
  - LOAD: count valid bits from 0 to REG_WIDTH-1.
    - On the REG_WIDTH-th bit, go to VERIFY.
    - Exception: if the resulting hist is all ones (the lockup pattern), restart the LOAD count and stay in LOAD.
  - VERIFY: count consecutive matches.
    - Any mismatch: go to LOAD with the count at 0.
    - On the CONFIRM-th match: go to LOCKED.
    - No errors are counted in VERIFY.
  - LOCKED: every valid bit increments bit_count and the window counter.
    - A mismatch increments err_count and the window error counter, and raises err_pulse.
    - When the window error counter reaches ERR_THRESH: go to LOAD. The counts for the next LOAD start at 0; hist is kept but fully reloaded.
    - When the window counter reaches WINDOW with the threshold not reached: clear both window counters.
- in_valid low: nothing advances in any state.
- clear: zeroes err_count and bit_count. It has priority over a same-cycle increment. err_pulse still fires for that bit.
- Counters saturate and never wrap.
- A single flipped bit in LOCKED produces exactly 3 errors, at offsets 0, +28 and +31 valid bits (k, k+REG_WIDTH-TAP and k+REG_WIDTH). This is intended.

## Timing
- All outputs are registered.
- Reset values: locked 0, err_pulse 0, err_count 0, bit_count 0, state LOAD, hist 0, all internal counters 0.
- Reset has priority over every other input, including mid-LOCKED; it forces relock from scratch.
- err_pulse: high exactly one cycle, the cycle after the mismatching valid bit is sampled.
- err_count and bit_count update on the same edge as err_pulse.
- Lock acquisition with in_valid held high from reset release: locked rises in the cycle after the (REG_WIDTH + CONFIRM)-th valid bit, which is bit 47 by default.
- Loss of lock: locked falls in the cycle after the bit that brought the window error count to ERR_THRESH. That bit is still counted in err_count.
- Throughput: one bit per clock, with no back-pressure.

## Test plan
- Acquisition: drive bit 0 of the team LFSR generator (REG_WIDTH 31, SEED 24218329) with in_valid always high.
  - Required: locked rises after exactly 47 valid bits.
  - After 1000 further bits: err_count 0 and bit_count 1000.
- Gapped valid: same stream with in_valid toggling pseudo-randomly at about 50%, stalling the source accordingly.
  - Required: lock after 47 valid bits and zero errors; bit_count equals the number of valid bits after lock.
- Single flip: after lock, invert one bit at index k.
  - Required: exactly 3 err_pulse at valid bits k, k+28 and k+31; err_count 3; locked stays 1.
- Loss and relock: after lock, invert 3 bits spaced 40 apart within one window, giving 9 errors.
  - Required: locked falls the cycle after the 8th error; err_count reaches 8.
  - Clean stream afterwards: relock after 47 more valid bits, and counters continue from 8.
- Lockup and garbage input:
  - Constant 1 input: locked never asserts.
  - Constant 0 input: prediction is 1, so VERIFY always fails and locked never asserts.
  - Mid-VERIFY mismatch: returns to LOAD.
- Clear, saturation and reset:
  - clear in the same cycle as an error: err_count 0 and err_pulse 1.
  - err_count forced near 0xFFFF by a long error burst with ERR_THRESH raised: holds at 0xFFFF.
  - rst asserted while locked: all outputs 0 on the next cycle.

Source files
------------

// File: rtl/prbs_bit_checker.sv
// prbs_bit_checker
// Serial checker for the XNOR-feedback LFSR stream (feedback = ~(r[TAP] ^ r[0]),
// right shift). It aligns itself to the sequence phase by loading REG_WIDTH
// received bits, confirms the alignment with CONFIRM correct predictions,
// then checks every following bit. While locked it keeps error statistics
// and drops lock when ERR_THRESH errors land inside one WINDOW of bits.
//
// Handshake: in_valid qualifies in_bit on the rising edge of clk. There is
// no ready; every cycle with in_valid high consumes exactly one bit, and
// with in_valid low no state, counter or history advances.
module prbs_bit_checker #(
  parameter int REG_WIDTH  = 31,
  parameter int TAP        = 3,
  parameter int CONFIRM    = 16,
  parameter int ERR_THRESH = 8,
  parameter int WINDOW     = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_bit,
  input  logic        clear,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count,
  output logic [31:0] bit_count
);

  localparam int LCW = $clog2(REG_WIDTH + 1);
  localparam int MCW = $clog2(CONFIRM + 1);
  localparam int WCW = $clog2(WINDOW + 1);
  localparam int ECW = $clog2(ERR_THRESH + 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // State register and its next value; state_q is the signal to probe when
  // watching the acquisition sequence.
  state_t               state_q;
  state_t               state_d;

  // History of received bits; hist_q[0] is the oldest bit.
  logic [REG_WIDTH-1:0] hist_q;
  logic [REG_WIDTH-1:0] hist_shift;

  logic [LCW-1:0]       load_cnt_q;
  logic [LCW-1:0]       load_cnt_d;
  logic [MCW-1:0]       match_cnt_q;
  logic [MCW-1:0]       match_cnt_d;
  logic [WCW-1:0]       win_cnt_q;
  logic [WCW-1:0]       win_cnt_d;
  logic [ECW-1:0]       win_err_q;
  logic [ECW-1:0]       win_err_d;

  logic                 exp_bit;
  logic                 mismatch;
  logic                 hist_lockup;
  logic                 err_hit;
  logic                 count_bit;

  // The received bit is always what enters the history, never the
  // prediction, so a corrupted bit is replayed through the taps later.
  assign hist_shift  = {in_bit, hist_q[REG_WIDTH-1:1]};
  assign exp_bit     = ~(hist_q[TAP] ^ hist_q[0]);
  assign mismatch    = (in_bit != exp_bit);
  // All ones is the XNOR lockup pattern: it predicts itself forever.
  assign hist_lockup = &hist_shift;

  // Next-state and counter logic for acquisition, verification and lock.
  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_hit     = 1'b0;
    count_bit   = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        ST_LOAD: begin
          if (load_cnt_q == LCW'(REG_WIDTH - 1)) begin
            // History is full; restart the load if it holds the lockup word.
            load_cnt_d = '0;
            if (!hist_lockup) begin
              state_d     = ST_VERIFY;
              match_cnt_d = '0;
            end
          end else begin
            load_cnt_d = load_cnt_q + LCW'(1);
          end
        end
        ST_VERIFY: begin
          if (mismatch) begin
            state_d    = ST_LOAD;
            load_cnt_d = '0;
          end else if (match_cnt_q == MCW'(CONFIRM - 1)) begin
            state_d   = ST_LOCKED;
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            match_cnt_d = match_cnt_q + MCW'(1);
          end
        end
        ST_LOCKED: begin
          count_bit = 1'b1;
          err_hit   = mismatch;
          if (mismatch && (win_err_q == ECW'(ERR_THRESH - 1))) begin
            // Too many errors in this window: reacquire from scratch.
            state_d     = ST_LOAD;
            load_cnt_d  = '0;
            match_cnt_d = '0;
            win_cnt_d   = '0;
            win_err_d   = '0;
          end else if (win_cnt_q == WCW'(WINDOW - 1)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WCW'(1);
            win_err_d = win_err_q + ECW'(mismatch);
          end
        end
        default: begin
          state_d    = ST_LOAD;
          load_cnt_d = '0;
        end
      endcase
    end
  end

  // State and internal counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      load_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
    end
  end

  // History shift register, advanced only on valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
    end else if (in_valid) begin
      hist_q <= hist_shift;
    end
  end

  // Registered status flags; locked follows the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      locked    <= (state_d == ST_LOCKED);
      err_pulse <= err_hit;
    end
  end

  // Saturating error counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (clear) begin
      err_count <= '0;
    end else if (err_hit && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end

  // Saturating checked-bit counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_count <= '0;
    end else if (clear) begin
      bit_count <= '0;
    end else if (count_bit && (bit_count != 32'hFFFF_FFFF)) begin
      bit_count <= bit_count + 32'd1;
    end
  end

endmodule
